// File: rtl/vram_slot_timing_gen.sv
// -----------------------------------------------------------------------------
// vram_slot_timing_gen
// Purpose: access-cycle timing generator for the tilemap VRAM. A free-running
// phase counter splits the master clock into a 2^PHASE_BITS-clock access cycle,
// produces the cycle strobes and arbitrates CPU VRAM requests into one or two
// CPU slots per cycle through a request/wait handshake.
//
// Ports:
//   clock       in   master clock, all state on rising edge
//   reset       in   asynchronous active-high reset
//   cpu_cs      in   CPU VRAM chip select (level)
//   cpu_rnw     in   1 = read, 0 = write, captured with the cpu_cs rising edge
//   slot_mode   in   0 = one CPU slot per cycle, 1 = two slots per cycle
//   rmrd        in   force VRAM data drive enable (ROM/readback mode)
//   phase       out  current phase counter value
//   clk_div     out  clock/2 (phase[0])
//   pe          out  high while phase is the last phase of the cycle
//   vram_latch  out  high while phase == LATCH_PHASE
//   pq          out  high during a CPU slot that is serving a request
//   rden        out  one-cycle VRAM read enable
//   wren        out  one-cycle VRAM write enable
//   cpu_wait    out  request pending, not yet served
//   cpu_done    out  one-cycle pulse the cycle after service
//   vde         out  CPU data drive enable (read hold OR rmrd)
// -----------------------------------------------------------------------------
module vram_slot_timing_gen #(
  parameter int unsigned PHASE_BITS  = 3,
  parameter int unsigned CPU_PHASE   = 4,
  parameter int unsigned LATCH_PHASE = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_cs,
  input  logic                  cpu_rnw,
  input  logic                  slot_mode,
  input  logic                  rmrd,
  output logic [PHASE_BITS-1:0] phase,
  output logic                  clk_div,
  output logic                  pe,
  output logic                  vram_latch,
  output logic                  pq,
  output logic                  rden,
  output logic                  wren,
  output logic                  cpu_wait,
  output logic                  cpu_done,
  output logic                  vde
);

  localparam int unsigned PERIOD = 32'd1 << PHASE_BITS;
  localparam logic [PHASE_BITS-1:0] LAST_PH  = PHASE_BITS'(PERIOD - 32'd1);
  localparam logic [PHASE_BITS-1:0] LATCH_PH = PHASE_BITS'(LATCH_PHASE);
  localparam logic [PHASE_BITS-1:0] SLOT_A   = PHASE_BITS'(CPU_PHASE);
  localparam logic [PHASE_BITS-1:0] SLOT_B   = PHASE_BITS'((CPU_PHASE + PERIOD / 32'd2) % PERIOD);

  logic [PHASE_BITS-1:0] r_phase;
  logic                  r_pe;
  logic                  r_latch;
  logic                  r_mode;
  logic                  r_cs_prev;
  logic                  r_pending;
  logic                  r_rnw;
  logic                  r_pq;
  logic                  r_rden;
  logic                  r_wren;
  logic                  r_done;
  logic                  r_rd_hold;

  logic [PHASE_BITS-1:0] w_phase_next;
  logic                  w_wrap;
  logic                  w_mode_next;
  logic                  w_slot_next;
  logic                  w_cs_rise;
  logic                  w_serve;

  // Next-phase decode: strobes are registered from these so they line up
  // exactly with the cycle that holds the decoded phase.
  always_comb begin
    w_phase_next = r_phase + PHASE_BITS'(1);
    w_wrap       = (w_phase_next == '0);
    // Mode only changes on entry to phase 0, so a slot is never half-enabled.
    w_mode_next  = w_wrap ? slot_mode : r_mode;
    w_slot_next  = (w_phase_next == SLOT_A) || (w_mode_next && (w_phase_next == SLOT_B));
    w_cs_rise    = cpu_cs & ~r_cs_prev;
    // Uses the pre-edge pending flag: a request captured on the edge into a
    // slot waits for the next slot. cpu_cs low on this edge cancels instead.
    w_serve      = w_slot_next & r_pending & cpu_cs & ~r_pq;
  end

  // Phase counter, strobes and request/service state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_phase   <= '0;
      r_pe      <= 1'b0;
      r_latch   <= 1'b0;
      r_mode    <= 1'b0;
      r_cs_prev <= 1'b0;
      r_pending <= 1'b0;
      r_rnw     <= 1'b0;
      r_pq      <= 1'b0;
      r_rden    <= 1'b0;
      r_wren    <= 1'b0;
      r_done    <= 1'b0;
      r_rd_hold <= 1'b0;
    end else begin
      r_phase   <= w_phase_next;
      r_pe      <= (w_phase_next == LAST_PH);
      r_latch   <= (w_phase_next == LATCH_PH);
      r_mode    <= w_mode_next;
      r_cs_prev <= cpu_cs;

      r_pq      <= w_serve;
      r_rden    <= w_serve & r_rnw;
      r_wren    <= w_serve & ~r_rnw;
      r_done    <= r_pq;

      // Completion wins, then cancel, then a fresh capture.
      if (r_pq) begin
        r_pending <= 1'b0;
      end else if (r_pending && !cpu_cs) begin
        r_pending <= 1'b0;
      end else if (w_cs_rise) begin
        r_pending <= 1'b1;
        r_rnw     <= cpu_rnw;
      end

      // Read data stays driven until the CPU releases chip select.
      if (w_serve && r_rnw) begin
        r_rd_hold <= 1'b1;
      end else if (!cpu_cs) begin
        r_rd_hold <= 1'b0;
      end
    end
  end

  assign phase      = r_phase;
  assign clk_div    = r_phase[0];
  assign pe         = r_pe;
  assign vram_latch = r_latch;
  assign pq         = r_pq;
  assign rden       = r_rden;
  assign wren       = r_wren;
  assign cpu_wait   = r_pending;
  assign cpu_done   = r_done;
  assign vde        = r_rd_hold | rmrd;

endmodule

// File: tb/tb_vram_slot_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vram_slot_timing_gen
// Purpose: self-checking bench for vram_slot_timing_gen with default
// parameters (8-clock cycle, CPU slot at phase 4, latch at phase 6).
// Stimulus pushes expected service/done events (kind + cycle number) into a
// queue; a monitor pops and compares whenever the DUT shows pq/rden/wren or
// cpu_done, and flags events that are late or unexpected.
// -----------------------------------------------------------------------------
module tb_vram_slot_timing_gen;

  logic       clock     = 1'b0;
  logic       reset     = 1'b1;
  logic       cpu_cs    = 1'b0;
  logic       cpu_rnw   = 1'b0;
  logic       slot_mode = 1'b0;
  logic       rmrd      = 1'b0;
  logic [2:0] phase;
  logic       clk_div, pe, vram_latch, pq, rden, wren, cpu_wait, cpu_done, vde;

  vram_slot_timing_gen #(
    .PHASE_BITS (3),
    .CPU_PHASE  (4),
    .LATCH_PHASE(6)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .cpu_cs    (cpu_cs),
    .cpu_rnw   (cpu_rnw),
    .slot_mode (slot_mode),
    .rmrd      (rmrd),
    .phase     (phase),
    .clk_div   (clk_div),
    .pe        (pe),
    .vram_latch(vram_latch),
    .pq        (pq),
    .rden      (rden),
    .wren      (wren),
    .cpu_wait  (cpu_wait),
    .cpu_done  (cpu_done),
    .vde       (vde)
  );

  always #5 clock = ~clock;

  localparam int EV_READ  = 1;
  localparam int EV_WRITE = 2;
  localparam int EV_DONE  = 3;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  ev_t        exp_q[$];
  int         n_checks = 0;
  int         n_err    = 0;
  int         tb_cyc   = 0;
  logic [2:0] tb_ph;

  // Reference phase: 0 in reset, +1 per clock afterwards.
  always @(posedge clock or posedge reset) begin
    if (reset) tb_ph <= 3'd0;
    else       tb_ph <= tb_ph + 3'd1;
  end

  always @(posedge clock) tb_cyc <= tb_cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, tb_cyc);
    end
  endtask

  task automatic push_ev(input int kind, input int cyc);
    ev_t e;
    e.kind = kind;
    e.cyc  = cyc;
    exp_q.push_back(e);
  endtask

  task automatic take_ev(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_err++;
      $display("FAIL unexpected_event: got kind %0d expected none (cycle %0d)", kind, tb_cyc);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      check("event_cycle", tb_cyc, e.cyc);
    end
  endtask

  // Monitor: cycle strobes every cycle, scoreboard on service/done events.
  always @(negedge clock) begin
    if (!reset) begin
      ev_t e;
      check("mon_phase", int'(phase), int'(tb_ph));
      check("mon_pe", int'(pe), int'(tb_ph == 3'd7));
      check("mon_latch", int'(vram_latch), int'(tb_ph == 3'd6));
      check("mon_clk_div", int'(clk_div), int'(tb_ph[0]));
      check("mon_pq_excl", int'(pq), int'(rden | wren));
      check("mon_rw_excl", int'(rden & wren), 0);
      while (exp_q.size() > 0 && exp_q[0].cyc < tb_cyc) begin
        e = exp_q.pop_front();
        n_checks++;
        n_err++;
        $display("FAIL missed_event: got nothing expected kind %0d at cycle %0d (now %0d)",
                 e.kind, e.cyc, tb_cyc);
      end
      if (pq || rden || wren) take_ev(rden ? EV_READ : EV_WRITE);
      if (cpu_done) take_ev(EV_DONE);
    end
  end

  task automatic wait_phase(input int p);
    int n = 0;
    while (int'(tb_ph) != p && n < 16) begin
      @(negedge clock);
      n++;
    end
    check("wait_phase", int'(tb_ph), p);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int cnt;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_phase", int'(phase), 0);
    check("rst_pe", int'(pe), 0);
    check("rst_latch", int'(vram_latch), 0);
    check("rst_pq", int'(pq), 0);
    check("rst_rden", int'(rden), 0);
    check("rst_wren", int'(wren), 0);
    check("rst_wait", int'(cpu_wait), 0);
    check("rst_done", int'(cpu_done), 0);
    check("rst_vde", int'(vde), 0);
    rmrd = 1'b1;
    #1 check("rst_vde_rmrd", int'(vde), 1);
    rmrd = 1'b0;

    // Free run: phase wraps, pe at 7/15/23, latch at 6/14/22
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 24; k++) begin
      if (k > 0) @(negedge clock);
      check("run_phase", int'(phase), k % 8);
      check("run_pe", int'(pe), int'(k == 7 || k == 15 || k == 23));
      check("run_latch", int'(vram_latch), int'(k == 6 || k == 14 || k == 22));
      check("run_clk_div", int'(clk_div), k % 2);
    end

    // Read sampled at edge into phase 1 -> served phase 4, done phase 5
    wait_phase(0);
    c = tb_cyc;
    cpu_rnw = 1'b1;
    cpu_cs  = 1'b1;
    push_ev(EV_READ, c + 4);
    push_ev(EV_DONE, c + 5);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      check("rd_wait", int'(cpu_wait), int'(k <= 4));
      check("rd_vde", int'(vde), int'(k >= 4));
    end
    @(negedge clock);
    check("rd_vde_hold", int'(vde), 1);
    cpu_cs = 1'b0;
    @(negedge clock);
    check("rd_vde_drop", int'(vde), 0);

    // Write captured on the edge into phase 4 -> waits for the next slot
    wait_phase(3);
    c = tb_cyc;
    cpu_rnw = 1'b0;
    cpu_cs  = 1'b1;
    push_ev(EV_WRITE, c + 9);
    push_ev(EV_DONE, c + 10);
    cnt = 0;
    repeat (12) begin
      @(negedge clock);
      if (cpu_wait) cnt++;
    end
    check("wr_wait_len", cnt, 9);
    cpu_cs = 1'b0;

    // Two-slot mode: read served at phase 4, second request at phase 0
    wait_phase(6);
    slot_mode = 1'b1;
    @(negedge clock);
    wait_phase(0);
    c = tb_cyc;
    cpu_rnw = 1'b1;
    cpu_cs  = 1'b1;
    push_ev(EV_READ, c + 4);
    push_ev(EV_DONE, c + 5);
    wait_phase(4);
    cpu_cs = 1'b0;
    @(negedge clock);
    cpu_rnw = 1'b0;
    cpu_cs  = 1'b1;
    push_ev(EV_WRITE, c + 8);
    push_ev(EV_DONE, c + 9);
    wait_phase(1);
    check("sm_wait_clear", int'(cpu_wait), 0);
    cpu_cs    = 1'b0;
    slot_mode = 1'b0;

    // Cancel: cpu_cs dropped while pending, no service and no done
    wait_phase(0);
    cpu_rnw = 1'b1;
    cpu_cs  = 1'b1;
    wait_phase(2);
    check("cn_wait_set", int'(cpu_wait), 1);
    cpu_cs = 1'b0;
    for (int k = 3; k <= 6; k++) begin
      @(negedge clock);
      check("cn_wait_clear", int'(cpu_wait), 0);
      check("cn_vde", int'(vde), 0);
    end
    rmrd = 1'b1;
    #1;
    check("cn_vde_rmrd", int'(vde), 1);
    check("cn_rden", int'(rden), 0);
    rmrd = 1'b0;
    #1 check("cn_vde_off", int'(vde), 0);

    // Reset with a request pending, then one service after release
    wait_phase(0);
    cpu_rnw = 1'b1;
    cpu_cs  = 1'b1;
    wait_phase(3);
    check("mr_wait_before", int'(cpu_wait), 1);
    reset = 1'b1;
    #1;
    check("mr_phase", int'(phase), 0);
    check("mr_pe", int'(pe), 0);
    check("mr_latch", int'(vram_latch), 0);
    check("mr_clk_div", int'(clk_div), 0);
    check("mr_pq", int'(pq), 0);
    check("mr_rden", int'(rden), 0);
    check("mr_wren", int'(wren), 0);
    check("mr_wait", int'(cpu_wait), 0);
    check("mr_done", int'(cpu_done), 0);
    check("mr_vde", int'(vde), 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    c = tb_cyc;
    push_ev(EV_READ, c + 4);
    push_ev(EV_DONE, c + 5);
    repeat (14) @(negedge clock);
    check("mr_wait_after", int'(cpu_wait), 0);
    cpu_cs = 1'b0;
    repeat (3) @(negedge clock);
    check("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
